// File: rtl/eth_nexthop_pkg.sv
// Shared definitions for the next-hop resolver: FSM state encoding,
// the broadcast MAC constant and default timing parameters.
package eth_nexthop_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_DECIDE   = 3'd2;
  localparam logic [2:0] ST_ARP_REQ  = 3'd3;
  localparam logic [2:0] ST_ARP_WAIT = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam int CHK_LATENCY_DEFAULT = 4;
  localparam int ARP_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/ip_next_hop_resolver.sv
// Next-hop MAC resolver: takes a destination IP, lets an external broadcast
// checker classify it, then answers with the broadcast MAC, an ARP-resolved
// MAC (for the host itself or the gateway) or an error.
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where both
// are high. A source holds valid and its payload stable until that edge; this
// block raises each ready/valid only from its current state, never from the
// partner's valid, so there are no combinational paths between interfaces.
module ip_next_hop_resolver
  import eth_nexthop_pkg::*;
#(
  parameter int CHK_LATENCY = CHK_LATENCY_DEFAULT,
  parameter int ARP_TIMEOUT = ARP_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  input  logic [31:0] s_req_ip,
  output logic        m_resp_valid,
  input  logic        m_resp_ready,
  output logic [47:0] m_resp_mac,
  output logic        m_resp_error,
  output logic [31:0] chk_dest_ip,
  input  logic        chk_is_broadcast,
  input  logic        chk_is_subnet_broadcast,
  input  logic        chk_is_local,
  output logic        arp_req_valid,
  input  logic        arp_req_ready,
  output logic [31:0] arp_req_ip,
  input  logic        arp_resp_valid,
  output logic        arp_resp_ready,
  input  logic        arp_resp_error,
  input  logic [47:0] arp_resp_mac,
  input  logic [31:0] gateway_ip,
  output logic [2:0]  dbg_state
);

  localparam int CHK_CW = (CHK_LATENCY < 1) ? 1 : $clog2(CHK_LATENCY + 1);
  localparam int TO_CW  = $clog2(ARP_TIMEOUT + 1);

  // Last count value of each phase: the phase ends in the cycle that holds it.
  localparam logic [CHK_CW-1:0] CHK_LAST = CHK_CW'((CHK_LATENCY < 1) ? 0 : CHK_LATENCY - 1);
  localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(ARP_TIMEOUT - 1);
  localparam logic [TO_CW-1:0]  TO_MAX   = TO_CW'(ARP_TIMEOUT);

  logic [2:0]        state;
  logic              ready_en;
  logic [CHK_CW-1:0] chk_cnt;
  logic [TO_CW-1:0]  arp_cnt;

  // Interface strobes come straight from the state; s_req_ready is held off
  // until the first clock after reset release.
  always_comb begin
    s_req_ready    = (state == ST_IDLE) && ready_en;
    m_resp_valid   = (state == ST_RESP);
    arp_req_valid  = (state == ST_ARP_REQ);
    arp_resp_ready = (state == ST_ARP_WAIT);
    dbg_state      = state;
  end

  // Lookup FSM with its registered request, ARP and response payloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ready_en     <= 1'b0;
      chk_dest_ip  <= 32'd0;
      chk_cnt      <= '0;
      arp_cnt      <= '0;
      arp_req_ip   <= 32'd0;
      m_resp_mac   <= 48'd0;
      m_resp_error <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (s_req_valid && ready_en) begin
            chk_dest_ip <= s_req_ip;
            chk_cnt     <= '0;
            state       <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Give the checker its full latency before trusting its flags.
          if (chk_cnt == CHK_LAST) state <= ST_DECIDE;
          else                     chk_cnt <= chk_cnt + 1'b1;
        end
        ST_DECIDE: begin
          if (chk_is_broadcast || chk_is_subnet_broadcast) begin
            m_resp_mac   <= BCAST_MAC;
            m_resp_error <= 1'b0;
            state        <= ST_RESP;
          end else if (chk_is_local) begin
            arp_req_ip <= chk_dest_ip;
            state      <= ST_ARP_REQ;
          end else if (gateway_ip != 32'd0) begin
            arp_req_ip <= gateway_ip;
            state      <= ST_ARP_REQ;
          end else begin
            m_resp_mac   <= 48'd0;
            m_resp_error <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_ARP_REQ: begin
          if (arp_req_ready) begin
            arp_cnt <= '0;
            state   <= ST_ARP_WAIT;
          end
        end
        ST_ARP_WAIT: begin
          // A response in the final waiting cycle still beats the timeout.
          if (arp_resp_valid) begin
            m_resp_mac   <= arp_resp_mac;
            m_resp_error <= arp_resp_error;
            state        <= ST_RESP;
          end else if (arp_cnt >= TO_LAST) begin
            m_resp_mac   <= 48'd0;
            m_resp_error <= 1'b1;
            state        <= ST_RESP;
          end else if (arp_cnt != TO_MAX) begin
            arp_cnt <= arp_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (m_resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_next_hop_resolver.sv
// Bench for ip_next_hop_resolver: emulates the broadcast checker and an ARP
// cache, predicts each lookup result from the routing rules, and checks
// handshakes, hold behaviour, latencies and reset.
module tb_ip_next_hop_resolver;

  localparam int CHK_LAT = 4;
  localparam int ARP_TO  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [31:0] s_req_ip = 32'd0;
  logic        m_resp_valid;
  logic        m_resp_ready = 1'b0;
  logic [47:0] m_resp_mac;
  logic        m_resp_error;
  logic [31:0] chk_dest_ip;
  logic        chk_is_broadcast;
  logic        chk_is_subnet_broadcast;
  logic        chk_is_local;
  logic        arp_req_valid;
  logic        arp_req_ready = 1'b0;
  logic [31:0] arp_req_ip;
  logic        arp_resp_valid = 1'b0;
  logic        arp_resp_ready;
  logic        arp_resp_error = 1'b0;
  logic [47:0] arp_resp_mac = 48'd0;
  logic [31:0] gw_ip = 32'd0;
  logic [2:0]  dbg_state;

  logic [31:0] my_ip    = 32'hC0A8_010A;  // 192.168.1.10
  logic [31:0] net_mask = 32'hFFFF_FF00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [48:0] exp_q[$];

  ip_next_hop_resolver #(.CHK_LATENCY(CHK_LAT), .ARP_TIMEOUT(ARP_TO)) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_ip(s_req_ip),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_mac(m_resp_mac), .m_resp_error(m_resp_error),
    .chk_dest_ip(chk_dest_ip), .chk_is_broadcast(chk_is_broadcast),
    .chk_is_subnet_broadcast(chk_is_subnet_broadcast), .chk_is_local(chk_is_local),
    .arp_req_valid(arp_req_valid), .arp_req_ready(arp_req_ready), .arp_req_ip(arp_req_ip),
    .arp_resp_valid(arp_resp_valid), .arp_resp_ready(arp_resp_ready),
    .arp_resp_error(arp_resp_error), .arp_resp_mac(arp_resp_mac),
    .gateway_ip(gw_ip), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Broadcast checker emulation (flags settle immediately, well within CHK_LAT)
  assign chk_is_broadcast        = (chk_dest_ip == 32'hFFFF_FFFF);
  assign chk_is_local            = ((chk_dest_ip ^ my_ip) & net_mask) == 32'd0;
  assign chk_is_subnet_broadcast = !chk_is_broadcast && chk_is_local &&
                                   ((chk_dest_ip | net_mask) == 32'hFFFF_FFFF);

  // Routing rules: 0 = broadcast, 1 = ARP for tgt, 2 = no route
  function automatic void route(input logic [31:0] ip, output int kind, output logic [31:0] tgt);
    bit on_link;
    on_link = ((ip ^ my_ip) & net_mask) == 32'd0;
    tgt = 32'd0;
    if (ip == 32'hFFFF_FFFF)                             kind = 0;
    else if (on_link && ((ip | net_mask) == 32'hFFFF_FFFF)) kind = 0;
    else if (on_link)                 begin kind = 1; tgt = ip;    end
    else if (gw_ip != 32'd0)          begin kind = 1; tgt = gw_ip; end
    else                                    kind = 2;
  endfunction

  // One full lookup. arp_delay < 0 means the ARP cache never answers.
  // Entered and left at #1 after a rising edge.
  task automatic drive_lookup(input logic [31:0] ip, input int arp_stall, input int arp_delay,
                              input logic [47:0] a_mac, input logic a_err,
                              input int resp_stall, input bit late_resp);
    int kind, acc_edge, wait_edge, resp_start, first_exp, budget, req_cnt, rsp_cnt;
    logic [31:0] tgt;
    logic [48:0] exp;
    bit done, resp_seen, arp_done, exp_ardy;
    route(ip, kind, tgt);
    if (kind == 0)      exp = {1'b0, 48'hFFFF_FFFF_FFFF};
    else if (kind == 2) exp = {1'b1, 48'd0};
    else if (arp_delay < 0 || arp_delay > ARP_TO - 1) exp = {1'b1, 48'd0};
    else                exp = {a_err, a_mac};
    exp_q.push_back(exp);

    s_req_valid = 1'b1;
    s_req_ip    = ip;
    budget = 0;
    while (!s_req_ready && budget < 20) begin @(posedge clk); #1; budget++; end
    checks++;
    if (s_req_ready !== 1'b1) begin
      $display("FAIL req_accept: s_req_ready=%b want 1", s_req_ready);
      errors++;
      s_req_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    acc_edge = cyc + 1;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    s_req_ip    = $urandom;

    done = 0; resp_seen = 0; arp_done = 0;
    wait_edge = -1; resp_start = -1; budget = 0; req_cnt = 0; rsp_cnt = 0;
    while (!done && budget < 400) begin
      checks++;
      if (s_req_ready !== 1'b0) begin
        $display("FAIL busy_ready: s_req_ready=%b want 0 at cyc %0d", s_req_ready, cyc); errors++;
      end
      checks++;
      if (chk_dest_ip !== ip) begin
        $display("FAIL chk_hold: chk_dest_ip=%h want %h", chk_dest_ip, ip); errors++;
      end
      exp_ardy = (wait_edge >= 0) && (cyc >= wait_edge) && (cyc < resp_start);
      checks++;
      if (arp_resp_ready !== exp_ardy) begin
        $display("FAIL arp_resp_ready: got %b want %b at cyc %0d", arp_resp_ready, exp_ardy, cyc); errors++;
      end
      // ARP request side
      arp_req_ready = 1'b0;
      if (arp_req_valid) begin
        checks++;
        if (kind != 1 || arp_req_ip !== tgt) begin
          $display("FAIL arp_req_ip: valid with ip=%h want kind 1 ip %h (kind %0d)", arp_req_ip, tgt, kind); errors++;
        end
        if (req_cnt >= arp_stall) begin
          arp_req_ready = 1'b1;
          wait_edge  = cyc + 1;
          resp_start = (arp_delay >= 0 && arp_delay <= ARP_TO - 1) ? wait_edge + arp_delay + 1
                                                                   : wait_edge + ARP_TO;
        end
        req_cnt++;
      end else if (req_cnt > 0 && wait_edge < 0) begin
        checks++;
        $display("FAIL arp_req_drop: arp_req_valid=0 want 1 before ready"); errors++;
      end
      // ARP response side
      arp_resp_valid = 1'b0;
      if (wait_edge >= 0 && !arp_done && arp_delay >= 0 && cyc >= wait_edge + arp_delay) begin
        arp_resp_valid = 1'b1;
        arp_resp_mac   = a_mac;
        arp_resp_error = a_err;
        if (arp_resp_ready) arp_done = 1;
      end
      // Lookup response side
      m_resp_ready = 1'b0;
      if (m_resp_valid) begin
        if (!resp_seen) begin
          resp_seen = 1;
          first_exp = (kind == 1) ? resp_start : acc_edge + CHK_LAT + 1;
          checks++;
          if (cyc !== first_exp) begin
            $display("FAIL resp_latency: resp at cyc %0d want %0d", cyc, first_exp); errors++;
          end
        end
        checks++;
        if ({m_resp_error, m_resp_mac} !== exp_q[0]) begin
          $display("FAIL resp_data: err/mac=%h want %h", {m_resp_error, m_resp_mac}, exp_q[0]); errors++;
        end
        if (rsp_cnt >= resp_stall) begin m_resp_ready = 1'b1; done = 1; end
        rsp_cnt++;
      end
      @(posedge clk); #1;
      budget++;
    end
    m_resp_ready   = 1'b0;
    arp_resp_valid = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (!done) begin
      $display("FAIL resp_timeout: no response within budget for ip %h", ip); errors++;
    end else if (m_resp_valid !== 1'b0 || s_req_ready !== 1'b1) begin
      $display("FAIL return_idle: m_resp_valid=%b s_req_ready=%b want 0/1", m_resp_valid, s_req_ready); errors++;
    end
    if (kind == 1) begin
      checks++;
      if (wait_edge < 0) begin $display("FAIL arp_missing: no ARP request seen want 1"); errors++; end
    end
    if (late_resp) begin
      for (int i = 0; i < 3; i++) begin
        arp_resp_valid = 1'b1;
        arp_resp_mac   = 48'h0BAD_0BAD_0BAD;
        checks++;
        if (arp_resp_ready !== 1'b0) begin
          $display("FAIL late_arp_ready: arp_resp_ready=%b want 0", arp_resp_ready); errors++;
        end
        @(posedge clk); #1;
      end
      arp_resp_valid = 1'b0;
      checks++;
      if (m_resp_valid !== 1'b0) begin
        $display("FAIL late_arp_resp: m_resp_valid=%b want 0", m_resp_valid); errors++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({s_req_ready, m_resp_valid, arp_req_valid, arp_resp_ready, m_resp_error} !== 5'b0 ||
        m_resp_mac !== 48'd0 || chk_dest_ip !== 32'd0 || arp_req_ip !== 32'd0) begin
      $display("FAIL reset_outputs: rdy/vld/arpv/arpr/err=%b mac=%h chk=%h arp=%h want all 0",
               {s_req_ready, m_resp_valid, arp_req_valid, arp_resp_ready, m_resp_error},
               m_resp_mac, chk_dest_ip, arp_req_ip);
      errors++;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (s_req_ready !== 1'b0) begin $display("FAIL reset_release_ready: got %b want 0", s_req_ready); errors++; end
    @(posedge clk); #1;
    checks++;
    if (s_req_ready !== 1'b1) begin $display("FAIL first_clock_ready: got %b want 1", s_req_ready); errors++; end
  endtask

  task automatic test_broadcast();
    gw_ip = 32'hC0A8_0101;
    drive_lookup(32'hFFFF_FFFF, 0, 0, 48'd0, 1'b0, 0, 0);
    drive_lookup(32'hC0A8_01FF, 0, 0, 48'd0, 1'b0, 1, 0);
  endtask

  task automatic test_local_arp();
    gw_ip = 32'hC0A8_0101;
    drive_lookup(32'hC0A8_0132, 0, 2, 48'h0200_0000_0032, 1'b0, 0, 0);
    drive_lookup(32'hC0A8_0133, 1, 0, 48'h0200_0000_0033, 1'b1, 0, 0);
  endtask

  task automatic test_gateway();
    gw_ip = 32'hC0A8_0101;
    drive_lookup(32'h0A00_0005, 0, 3, 48'h0200_0000_0001, 1'b0, 0, 0);
    gw_ip = 32'd0;
    drive_lookup(32'h0A00_0005, 0, 3, 48'h0200_0000_0001, 1'b0, 0, 0);
    gw_ip = 32'hC0A8_0101;
  endtask

  task automatic test_timeout();
    drive_lookup(32'hC0A8_0140, 0, -1, 48'd0, 1'b0, 3, 1);
    drive_lookup(32'hC0A8_0141, 0, ARP_TO + 1, 48'h0200_0000_00AA, 1'b0, 4, 0);
    drive_lookup(32'hC0A8_0142, 0, ARP_TO - 1, 48'h0200_0000_00BB, 1'b0, 0, 0);
    drive_lookup(32'hC0A8_0143, 0, ARP_TO, 48'h0200_0000_00CC, 1'b0, 0, 0);
  endtask

  task automatic test_backpressure();
    drive_lookup(32'hC0A8_0150, 5, 2, 48'h0200_0000_0050, 1'b0, 3, 0);
    drive_lookup(32'h0808_0808, 5, 0, 48'h0200_0000_0051, 1'b0, 3, 0);
  endtask

  task automatic test_reset_mid();
    int budget;
    s_req_valid = 1'b1;
    s_req_ip    = 32'hC0A8_014D;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    budget = 0;
    while (!arp_req_valid && budget < 30) begin @(posedge clk); #1; budget++; end
    arp_req_ready = 1'b1;
    @(posedge clk); #1;
    arp_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (arp_resp_ready !== 1'b1) begin $display("FAIL mid_in_wait: arp_resp_ready=%b want 1", arp_resp_ready); errors++; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s_req_ready, m_resp_valid, arp_req_valid, arp_resp_ready, m_resp_error} !== 5'b0 ||
        m_resp_mac !== 48'd0 || chk_dest_ip !== 32'd0 || arp_req_ip !== 32'd0) begin
      $display("FAIL mid_reset_outputs: rdy/vld/arpv/arpr/err=%b mac=%h chk=%h arp=%h want all 0",
               {s_req_ready, m_resp_valid, arp_req_valid, arp_resp_ready, m_resp_error},
               m_resp_mac, chk_dest_ip, arp_req_ip);
      errors++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_resp_valid !== 1'b0 || arp_req_valid !== 1'b0 || s_req_ready !== 1'b1) begin
      $display("FAIL mid_after_release: vld=%b arpv=%b rdy=%b want 0/0/1", m_resp_valid, arp_req_valid, s_req_ready);
      errors++;
    end
    drive_lookup(32'hC0A8_014E, 0, 1, 48'h0200_0000_004E, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      drive_lookup((i % 2 == 0) ? 32'hFFFF_FFFF : 32'hC0A8_0160 + i, 0, 0,
                   48'h0200_0000_0060 + i, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] ip;
    int sel, delay;
    for (int i = 0; i < 30; i++) begin
      net_mask = ($urandom_range(0, 3) == 0) ? 32'hFFFF_0000 : 32'hFFFF_FF00;
      gw_ip    = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'hC0A8_0101;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       ip = 32'hFFFF_FFFF;
        1:       ip = my_ip | ~net_mask;
        2:       ip = (my_ip & net_mask) | ($urandom & ~net_mask);
        default: ip = $urandom;
      endcase
      delay = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, ARP_TO + 2);
      drive_lookup(ip, $urandom_range(0, 3), delay, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF,
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end
    net_mask = 32'hFFFF_FF00;
    gw_ip    = 32'hC0A8_0101;
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_local_arp();
    test_gateway();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
